router_output_ctrl_arb_sep: RTL and testbench

- Output-port-side arbiter for the two-domain separated router.
- Collects single-flit requests from the three router input controls and picks one winner per cycle when the downstream channel is ready.
- Returns one-hot grants and the crossbar select to the input side.
- Each request carries a security-domain bit (0 = D1, 1 = D2). Arbitration alternates domain priority and keeps a separate round-robin pointer per domain, so neither domain's traffic history moves the other domain's pointer.

---
 rtl/router_output_ctrl_arb_sep_if.sv | 22 ++
 rtl/router_output_ctrl_arb_sep.sv | 103 ++++++++++
 tb/tb_router_output_ctrl_arb_sep.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/router_output_ctrl_arb_sep_if.sv
// Request/grant bundle between the three input controls and one output-port arbiter.
// master: input side (drives requests, domain bits and downstream ready); slave: arbiter.
// Signals: reqs/req_domain (per-port request + security domain), out_rdy, grants, sel, out_val, out_domain.
interface router_output_ctrl_arb_sep_if;
  logic [2:0] reqs;
  logic [2:0] req_domain;
  logic       out_rdy;
  logic [2:0] grants;
  logic [1:0] sel;
  logic       out_val;
  logic       out_domain;

  modport master (
    output reqs, req_domain, out_rdy,
    input  grants, sel, out_val, out_domain
  );

  modport slave (
    input  reqs, req_domain, out_rdy,
    output grants, sel, out_val, out_domain
  );
endinterface

// File: rtl/router_output_ctrl_arb_sep.sv
// Purpose: two-domain output-port arbiter, alternating domain priority, one round-robin pointer per domain.
// Latency: grants/sel/out_val/out_domain are combinational from the inputs (zero cycles).
// Backpressure: nothing is granted while out_rdy=0; priority and pointers hold until a transfer.
//
// Ports: clk, reset (async active-low), bus (slave modport): reqs, req_domain, out_rdy in;
//        grants (one-hot), sel (winner index), out_val, out_domain out.
// Optional macro ROUTER_OUTPUT_ARB_TDM_EN: strict time-division -- priority toggles every cycle
// and only the priority domain may win; undefined gives the work-conserving arbiter.
module router_output_ctrl_arb_sep #(
  parameter int   p_num_inputs   = 3,
  parameter logic p_reset_domain = 1'b0
) (
  input logic                          clk,
  input logic                          reset,
  router_output_ctrl_arb_sep_if.slave  bus
);

  if (p_num_inputs != 3) begin : g_bad_width
    $error("router_output_ctrl_arb_sep supports exactly 3 inputs");
  end

  logic       dom_pri;
  logic [1:0] ptr_d0;
  logic [1:0] ptr_d1;

  logic [2:0] m0;
  logic [2:0] m1;
  logic       has_win;
  logic       win_dom;
  logic [1:0] win_idx;
  logic       xfer;

  // Modulo-3 increment; pointers never hold 3.
  function automatic logic [1:0] inc_mod3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // First set bit of mask scanning ptr, ptr+1, ptr+2 (mod 3). Later checks
  // overwrite earlier ones, so the position nearest ptr wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] mask, input logic [1:0] ptr);
    logic [1:0] i0, i1, i2, pick;
    i0   = ptr;
    i1   = inc_mod3(i0);
    i2   = inc_mod3(i1);
    pick = 2'd0;
    if (mask[i2]) pick = i2;
    if (mask[i1]) pick = i1;
    if (mask[i0]) pick = i0;
    return pick;
  endfunction

  always_comb begin
    // Masking with reqs first keeps an unknown domain bit on an idle port out of the decision.
    m0 = bus.reqs & ~bus.req_domain;
    m1 = bus.reqs &  bus.req_domain;

    win_dom = dom_pri;
`ifdef ROUTER_OUTPUT_ARB_TDM_EN
    has_win = dom_pri ? (|m1) : (|m0);
`else
    has_win = (|m0) | (|m1);
    if (dom_pri ? ~(|m1) : ~(|m0)) begin
      win_dom = ~dom_pri;
    end
`endif

    win_idx = win_dom ? rr_pick(m1, ptr_d1) : rr_pick(m0, ptr_d0);

    // Gating with reset keeps grants off while the arbiter is held in reset.
    xfer = has_win & bus.out_rdy & reset;

    bus.grants     = 3'b000;
    bus.sel        = 2'd0;
    bus.out_val    = 1'b0;
    bus.out_domain = 1'b0;
    if (xfer) begin
      bus.grants[win_idx] = 1'b1;
      bus.sel             = win_idx;
      bus.out_val         = 1'b1;
      bus.out_domain      = win_dom;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dom_pri <= p_reset_domain;
      ptr_d0  <= 2'd0;
      ptr_d1  <= 2'd0;
    end else begin
`ifdef ROUTER_OUTPUT_ARB_TDM_EN
      dom_pri <= ~dom_pri;
`else
      if (xfer) dom_pri <= ~win_dom;
`endif
      // Only the winning domain's pointer advances; the other domain never sees this traffic.
      if (xfer) begin
        if (win_dom) ptr_d1 <= inc_mod3(win_idx);
        else         ptr_d0 <= inc_mod3(win_idx);
      end
    end
  end

endmodule

// File: tb/tb_router_output_ctrl_arb_sep.sv
module tb_router_output_ctrl_arb_sep;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  router_output_ctrl_arb_sep_if bus ();

  router_output_ctrl_arb_sep #(
    .p_num_inputs  (3),
    .p_reset_domain(1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ROUTER_OUTPUT_ARB_TDM_EN
  localparam int N_ORDER = 1;
`else
  localparam int N_ORDER = 2;
`endif

  // Behavioural model: priority domain and per-domain round-robin pointers.
  int m_pri;
  int m_ptr [2];

  always @(negedge clk) begin : model
    logic [2:0] eg;
    logic [1:0] es;
    logic       ev;
    logic       ed;
    int         d, p, wd, wi;
    bit         found;
    eg = 3'b000; es = 2'd0; ev = 1'b0; ed = 1'b0;
    found = 0; wd = 0; wi = 0;
    if (reset) begin
      for (int o = 0; o < N_ORDER; o++) begin
        d = (o == 0) ? m_pri : 1 - m_pri;
        for (int k = 0; k < 3; k++) begin
          p = (m_ptr[d] + k) % 3;
          if (!found && bus.reqs[p] && (int'(bus.req_domain[p]) == d)) begin
            found = 1; wd = d; wi = p;
          end
        end
      end
      if (found && bus.out_rdy) begin
        eg[wi] = 1'b1; es = 2'(wi); ev = 1'b1; ed = 1'(wd);
      end
    end
    checks++;
    if ({bus.grants, bus.sel, bus.out_val, bus.out_domain} !== {eg, es, ev, ed}) begin
      errors++;
      $display("FAIL model_cmp t=%0t: got grants=%b sel=%0d val=%b dom=%b, expected grants=%b sel=%0d val=%b dom=%b",
               $time, bus.grants, bus.sel, bus.out_val, bus.out_domain, eg, es, ev, ed);
    end
    if (!reset) begin
      m_pri = 0; m_ptr[0] = 0; m_ptr[1] = 0;
    end else begin
`ifdef ROUTER_OUTPUT_ARB_TDM_EN
      m_pri = 1 - m_pri;
`endif
      if (ev) begin
        m_ptr[wd] = (wi + 1) % 3;
`ifndef ROUTER_OUTPUT_ARB_TDM_EN
        m_pri = 1 - wd;
`endif
      end
    end
  end

  // One cycle with reset released; exp = {grants, out_domain} hand-computed.
  task automatic step(input string name, input logic [2:0] r, input logic [2:0] d,
                      input logic rdy, input logic [3:0] exp);
    @(posedge clk); #1;
    reset = 1'b1; bus.reqs = r; bus.req_domain = d; bus.out_rdy = rdy;
    @(negedge clk); #1;
    checks++;
    if ({bus.grants, bus.out_domain} !== exp) begin
      errors++;
      $display("FAIL %s: got grants=%b dom=%b, expected grants=%b dom=%b",
               name, bus.grants, bus.out_domain, exp[3:1], exp[0]);
    end
  endtask

  // One cycle held in reset: every output must be zero regardless of requests.
  task automatic rst_step(input string name, input logic [2:0] r, input logic [2:0] d, input logic rdy);
    @(posedge clk); #1;
    reset = 1'b0; bus.reqs = r; bus.req_domain = d; bus.out_rdy = rdy;
    @(negedge clk); #1;
    checks++;
    if ({bus.grants, bus.sel, bus.out_val, bus.out_domain} !== 7'd0) begin
      errors++;
      $display("FAIL %s: got grants=%b sel=%0d val=%b dom=%b, expected all zero",
               name, bus.grants, bus.sel, bus.out_val, bus.out_domain);
    end
  endtask

  logic [6:0] mix [10];

  initial begin
    checks = 0; errors = 0;
    m_pri = 0; m_ptr[0] = 0; m_ptr[1] = 0;
    reset = 1'b0; bus.reqs = 3'b000; bus.req_domain = 3'b000; bus.out_rdy = 1'b0;

    rst_step("reset_idle", 3'b000, 3'b000, 1'b0);

`ifndef ROUTER_OUTPUT_ARB_TDM_EN
    // Same-domain pair: pointer order alone decides.
    step("d1_pair_c0", 3'b101, 3'b000, 1'b1, 4'b001_0);
    step("d1_pair_c1", 3'b101, 3'b000, 1'b1, 4'b100_0);
    step("d1_pair_c2", 3'b101, 3'b000, 1'b1, 4'b001_0);

    // Cross-domain saturation ping-pongs.
    rst_step("reset_b", 3'b000, 3'b000, 1'b0);
    step("xdom_c0", 3'b011, 3'b010, 1'b1, 4'b001_0);
    step("xdom_c1", 3'b011, 3'b010, 1'b1, 4'b010_1);
    step("xdom_c2", 3'b011, 3'b010, 1'b1, 4'b001_0);
    step("xdom_c3", 3'b011, 3'b010, 1'b1, 4'b010_1);

    // Stall: no grants, no state movement.
    rst_step("reset_c", 3'b000, 3'b000, 1'b0);
    step("stall_c0", 3'b111, 3'b000, 1'b0, 4'b000_0);
    step("stall_c1", 3'b111, 3'b000, 1'b0, 4'b000_0);
    step("stall_c2", 3'b111, 3'b000, 1'b0, 4'b000_0);
    step("stall_release", 3'b111, 3'b000, 1'b1, 4'b001_0);

    // Only D2 requests with D1 priority: work-conserving, D1 pointer untouched.
    rst_step("reset_d", 3'b000, 3'b000, 1'b0);
    step("d2only_c0", 3'b100, 3'b100, 1'b1, 4'b100_1);
    step("d2only_c1", 3'b100, 3'b100, 1'b1, 4'b100_1);
    step("d2only_c2", 3'b100, 3'b100, 1'b1, 4'b100_1);
    step("d1_ptr_kept", 3'b111, 3'b000, 1'b1, 4'b001_0);

    // Reset mid-stream after two D1 grants.
    rst_step("reset_e", 3'b000, 3'b000, 1'b0);
    step("mid_c0", 3'b111, 3'b000, 1'b1, 4'b001_0);
    step("mid_c1", 3'b111, 3'b000, 1'b1, 4'b010_0);
    rst_step("mid_reset_gate", 3'b111, 3'b000, 1'b1);
    step("mid_after_reset", 3'b111, 3'b000, 1'b1, 4'b001_0);
`else
    // Time division: D1-only traffic is granted in D1 slots only.
    step("tdm_c0", 3'b001, 3'b000, 1'b1, 4'b001_0);
    step("tdm_c1", 3'b001, 3'b000, 1'b1, 4'b000_0);
    step("tdm_c2", 3'b001, 3'b000, 1'b1, 4'b001_0);
    step("tdm_c3", 3'b001, 3'b000, 1'b1, 4'b000_0);
`endif

    // Mixed traffic checked by the model only: {reqs, req_domain, out_rdy}.
    mix = '{7'b111_101_1, 7'b111_101_1, 7'b110_010_0, 7'b110_010_1, 7'b011_011_1,
            7'b101_001_1, 7'b111_111_1, 7'b111_111_1, 7'b010_000_1, 7'b111_010_1};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      bus.reqs = mix[i][6:4]; bus.req_domain = mix[i][3:1]; bus.out_rdy = mix[i][0];
    end

    @(posedge clk); #1;
    bus.reqs = 3'b000; bus.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
